// File: rtl/mmio_pwm.sv
// mmio_pwm: memory-mapped multi-channel PWM peripheral for the RV32I data bus.
// PERIOD and DUTY are double-buffered; the active copies reload at period wrap
// (or continuously while disabled), so software updates never cut a pulse short.
module mmio_pwm #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    parameter int PRE_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sel,
    input  logic              wren,
    input  logic [2:0]        funct3,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              wrap_irq
);

    // Word indices (byte offset >> 2) of the register map.
    localparam logic [5:0] IDX_CTRL     = 6'd0;
    localparam logic [5:0] IDX_PRESCALE = 6'd1;
    localparam logic [5:0] IDX_PERIOD   = 6'd2;
    localparam logic [5:0] IDX_CH_EN    = 6'd3;
    localparam logic [5:0] IDX_DUTY0    = 6'd4;

    localparam logic [2:0] FUNCT3_WORD  = 3'b010;

    // Software-visible registers.
    logic              en_q, en_d;
    logic              wrap_q, wrap_d;
    logic [PRE_W-1:0]  prescale_q, prescale_d;
    logic [WIDTH-1:0]  period_pend_q, period_pend_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic [WIDTH-1:0]  duty_pend_q [NUM_CH];
    logic [WIDTH-1:0]  duty_pend_d [NUM_CH];

    // Active (shadow) copies and timebase.
    logic [WIDTH-1:0]  period_act_q, period_act_d;
    logic [WIDTH-1:0]  duty_act_q [NUM_CH];
    logic [WIDTH-1:0]  duty_act_d [NUM_CH];
    logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;

    // Registered outputs.
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [31:0]       rdata_q, rdata_d;

    // Decode and timebase strobes.
    logic [5:0]        word_idx;
    logic              wr_en;
    logic              wr_ctrl, wr_prescale, wr_period, wr_ch_en;
    logic [NUM_CH-1:0] wr_duty;
    logic              tick;
    logic              wrap_evt;
    logic [31:0]       rd_val;

    // Byte-lane bits of the address and unused upper data bits are don't-care.
    logic              unused_bits;

    assign word_idx    = addr[7:2];
    assign wr_en       = sel & wren & (funct3 == FUNCT3_WORD);
    assign unused_bits = ^{addr[1:0], wdata};

    // Decode word writes into per-register strobes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ctrl     = 1'b0;
        wr_prescale = 1'b0;
        wr_period   = 1'b0;
        wr_ch_en    = 1'b0;
        wr_duty     = '0;
        if (wr_en) begin
            wr_ctrl     = (word_idx == IDX_CTRL);
            wr_prescale = (word_idx == IDX_PRESCALE);
            wr_period   = (word_idx == IDX_PERIOD);
            wr_ch_en    = (word_idx == IDX_CH_EN);
            for (int i = 0; i < NUM_CH; i++) begin
                wr_duty[i] = (word_idx == IDX_DUTY0 + 6'(i));
            end
        end
    end

    // Prescaler and period counter; both held at zero while disabled.
    always_comb begin
        tick      = en_q && (pre_cnt_q == prescale_q);
        wrap_evt  = tick && (cnt_q == period_act_q);
        pre_cnt_d = '0;
        cnt_d     = '0;
        if (en_q) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
            if (wrap_evt) begin
                cnt_d = '0;
            end else if (tick) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Register-file writes; WRAP set by a wrap event wins over a same-cycle clear.
    always_comb begin
        en_d          = en_q;
        wrap_d        = wrap_q;
        prescale_d    = prescale_q;
        period_pend_d = period_pend_q;
        ch_en_d       = ch_en_q;
        duty_pend_d   = duty_pend_q;
        if (wr_ctrl) begin
            en_d = wdata[0];
            if (wdata[1]) begin
                wrap_d = 1'b0;
            end
        end
        if (wrap_evt) begin
            wrap_d = 1'b1;
        end
        if (wr_prescale) begin
            prescale_d = wdata[PRE_W-1:0];
        end
        if (wr_period) begin
            period_pend_d = wdata[WIDTH-1:0];
        end
        if (wr_ch_en) begin
            ch_en_d = wdata[NUM_CH-1:0];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_duty[i]) begin
                duty_pend_d[i] = wdata[WIDTH-1:0];
            end
        end
    end

    // Shadow reload at wrap (or every cycle while disabled) and PWM compare.
    always_comb begin
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        if (!en_q || wrap_evt) begin
            period_act_d = period_pend_q;
            duty_act_d   = duty_pend_q;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = en_q && ch_en_q[i] && (cnt_q < duty_act_q[i]);
        end
    end

    // Read mux; rdata only updates on a selected read and otherwise holds.
    always_comb begin
        rd_val = '0;
        case (word_idx)
            IDX_CTRL:     rd_val = {30'd0, wrap_q, en_q};
            IDX_PRESCALE: rd_val = 32'(prescale_q);
            IDX_PERIOD:   rd_val = 32'(period_pend_q);
            IDX_CH_EN:    rd_val = 32'(ch_en_q);
            default:      rd_val = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (word_idx == IDX_DUTY0 + 6'(i)) begin
                rd_val = 32'(duty_pend_q[i]);
            end
        end
        rdata_d = (sel && !wren) ? rd_val : rdata_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            en_q          <= 1'b0;
            wrap_q        <= 1'b0;
            prescale_q    <= '0;
            period_pend_q <= '0;
            ch_en_q       <= '0;
            period_act_q  <= '0;
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            pwm_q         <= '0;
            rdata_q       <= '0;
            // NOTE: the duty arrays are a handful of software-visible flops, not RAM, so they are reset element by element.
            for (int i = 0; i < NUM_CH; i++) begin
                duty_pend_q[i] <= '0;
                duty_act_q[i]  <= '0;
            end
        end else begin
            en_q          <= en_d;
            wrap_q        <= wrap_d;
            prescale_q    <= prescale_d;
            period_pend_q <= period_pend_d;
            ch_en_q       <= ch_en_d;
            period_act_q  <= period_act_d;
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            pwm_q         <= pwm_d;
            rdata_q       <= rdata_d;
            duty_pend_q   <= duty_pend_d;
            duty_act_q    <= duty_act_d;
        end
    end

    assign rdata    = rdata_q;
    assign pwm_out  = pwm_q;
    assign wrap_irq = wrap_q;

endmodule

// File: tb/tb_mmio_pwm.sv
// tb_mmio_pwm: directed tests for mmio_pwm. Inputs are driven just after the
// falling edge and outputs sampled on the falling edge; "k" counts rising
// edges after the one that set EN=1.
module tb_mmio_pwm;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;
    localparam int PRE_W  = 16;

    localparam logic [7:0] A_CTRL     = 8'h00;
    localparam logic [7:0] A_PRESCALE = 8'h04;
    localparam logic [7:0] A_PERIOD   = 8'h08;
    localparam logic [7:0] A_CH_EN    = 8'h0C;
    localparam logic [7:0] A_DUTY0    = 8'h10;
    localparam logic [7:0] A_DUTY1    = 8'h14;
    localparam logic [7:0] A_DUTY2    = 8'h18;
    localparam logic [7:0] A_DUTY3    = 8'h1C;
    localparam logic [7:0] A_UNMAPPED = 8'hFC;

    logic              clk = 1'b0;
    logic              reset;
    logic              sel;
    logic              wren;
    logic [2:0]        funct3;
    logic [7:0]        addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pwm_out;
    logic              wrap_irq;

    int total = 0;
    int bad   = 0;

    mmio_pwm #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .wren     (wren),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .pwm_out  (pwm_out),
        .wrap_irq (wrap_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic bus_idle();
        sel    = 1'b0;
        wren   = 1'b0;
        funct3 = 3'b010;
        addr   = 8'h00;
        wdata  = 32'h0;
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d, input logic [2:0] f);
        sel    = 1'b1;
        wren   = 1'b1;
        funct3 = f;
        addr   = a;
        wdata  = d;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] f);
        set_wr(a, d, f);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        sel    = 1'b1;
        wren   = 1'b0;
        funct3 = 3'b010;
        addr   = a;
        @(negedge clk);
        bus_idle();
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Program registers with EN=0, then enable; returns right after edge k=0.
    task automatic setup(input logic [15:0] pre, input logic [15:0] per,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3,
                         input logic [3:0] chen);
        bus_write(A_PRESCALE, {16'h0, pre}, 3'b010);
        bus_write(A_PERIOD,   {16'h0, per}, 3'b010);
        bus_write(A_DUTY0,    {16'h0, d0},  3'b010);
        bus_write(A_DUTY1,    {16'h0, d1},  3'b010);
        bus_write(A_DUTY2,    {16'h0, d2},  3'b010);
        bus_write(A_DUTY3,    {16'h0, d3},  3'b010);
        bus_write(A_CH_EN,    {28'h0, chen}, 3'b010);
        bus_write(A_CTRL,     32'h1, 3'b010);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [7:0]  a;
        do_reset();
        setup(16'd0, 16'd9, 16'd3, 16'd2, 16'd1, 16'd5, 4'hF);
        bus_read(A_PERIOD, d);
        total++;
        if (d !== 32'd9) begin
            bad++;
            $display("FAIL reset_pre_read: got %0h want 9", d);
        end
        total++;
        if (pwm_out !== 4'hF) begin
            bad++;
            $display("FAIL reset_pre_pwm: got %b want 1111", pwm_out);
        end
        // Reset coincides with a write; reset must win.
        set_wr(A_DUTY0, 32'h55, 3'b010);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_idle();
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %0h want 0", rdata);
        end
        total++;
        if (pwm_out !== 4'h0) begin
            bad++;
            $display("FAIL reset_pwm: got %b want 0000", pwm_out);
        end
        total++;
        if (wrap_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_wrap_irq: got %b want 0", wrap_irq);
        end
        for (int i = 0; i < 8; i++) begin
            a = 8'(i * 4);
            bus_read(a, d);
            total++;
            if (d !== 32'h0) begin
                bad++;
                $display("FAIL reset_read off=%0h: got %0h want 0", a, d);
            end
        end
        total++;
        if (pwm_out !== 4'h0) begin
            bad++;
            $display("FAIL reset_pwm_after_reads: got %b want 0000", pwm_out);
        end
    endtask

    task automatic test_waveform();
        logic e;
        do_reset();
        setup(16'd0, 16'd9, 16'd3, 16'd0, 16'd0, 16'd0, 4'h1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus_idle();
            e = ((k - 1) % 10) < 3;
            total++;
            if (pwm_out[0] !== e) begin
                bad++;
                $display("FAIL wave_ch0 k=%0d: got %b want %b", k, pwm_out[0], e);
            end
            if (k == 1) begin
                total++;
                if (pwm_out[3:1] !== 3'b000) begin
                    bad++;
                    $display("FAIL wave_other_ch: got %b want 000", pwm_out[3:1]);
                end
            end
            if (k == 9) begin
                total++;
                if (wrap_irq !== 1'b0) begin
                    bad++;
                    $display("FAIL wave_wrap_early: got %b want 0", wrap_irq);
                end
            end
            if (k == 10) begin
                total++;
                if (wrap_irq !== 1'b1) begin
                    bad++;
                    $display("FAIL wave_wrap_set: got %b want 1", wrap_irq);
                end
            end
            if (k == 13) begin
                total++;
                if (rdata !== 32'h3) begin
                    bad++;
                    $display("FAIL wave_ctrl_read: got %0h want 3", rdata);
                end
            end
            if (k == 12) begin
                sel  = 1'b1;
                wren = 1'b0;
                addr = A_CTRL;
            end
        end
    endtask

    // DUTY0 3->7 written at k=wr_k; old duty applies up to k=last_old.
    task automatic test_glitch(input int wr_k, input int last_old);
        logic e;
        int   duty;
        do_reset();
        setup(16'd0, 16'd9, 16'd3, 16'd0, 16'd0, 16'd0, 4'h1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bus_idle();
            duty = (k <= last_old) ? 3 : 7;
            e = ((k - 1) % 10) < duty;
            total++;
            if (pwm_out[0] !== e) begin
                bad++;
                $display("FAIL glitch_wr%0d k=%0d: got %b want %b", wr_k, k, pwm_out[0], e);
            end
            if (k == wr_k + 3) begin
                total++;
                if (rdata !== 32'd7) begin
                    bad++;
                    $display("FAIL glitch_pending_read wr%0d: got %0h want 7", wr_k, rdata);
                end
            end
            if (k == wr_k) begin
                set_wr(A_DUTY0, 32'd7, 3'b010);
            end
            if (k == wr_k + 2) begin
                sel  = 1'b1;
                wren = 1'b0;
                addr = A_DUTY0;
            end
        end
    endtask

    task automatic test_prescale();
        logic [3:0] e;
        do_reset();
        setup(16'd2, 16'd3, 16'd0, 16'd4, 16'd2, 16'd1, 4'h7);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            e = 4'b0010 | (((((k - 1) / 3) % 4) < 2) ? 4'b0100 : 4'b0000);
            total++;
            if (pwm_out !== e) begin
                bad++;
                $display("FAIL prescale k=%0d: got %b want %b", k, pwm_out, e);
            end
        end
    endtask

    task automatic test_rejected();
        logic [31:0] d;
        do_reset();
        bus_write(A_DUTY0, 32'd5, 3'b010);
        bus_read(A_DUTY0, d);
        total++;
        if (d !== 32'd5) begin
            bad++;
            $display("FAIL rej_word_write: got %0h want 5", d);
        end
        bus_write(A_DUTY0, 32'hAA, 3'b000);
        bus_write(A_DUTY0, 32'hBB, 3'b001);
        bus_read(A_DUTY0, d);
        total++;
        if (d !== 32'd5) begin
            bad++;
            $display("FAIL rej_subword_write: got %0h want 5", d);
        end
        // Write strobe with sel low.
        sel    = 1'b0;
        wren   = 1'b1;
        funct3 = 3'b010;
        addr   = A_DUTY0;
        wdata  = 32'd9;
        @(negedge clk);
        bus_idle();
        bus_write(A_UNMAPPED, 32'h1234, 3'b010);
        bus_read(8'h13, d);
        total++;
        if (d !== 32'd5) begin
            bad++;
            $display("FAIL rej_sel0_write_or_lowbits: got %0h want 5", d);
        end
        @(negedge clk);
        total++;
        if (rdata !== 32'd5) begin
            bad++;
            $display("FAIL rej_rdata_hold: got %0h want 5", rdata);
        end
        bus_read(A_UNMAPPED, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL rej_unmapped_read: got %0h want 0", d);
        end
        bus_read(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL rej_ctrl_untouched: got %0h want 0", d);
        end
        bus_write(A_PERIOD, 32'hFFFF_FFFF, 3'b010);
        bus_read(A_PERIOD, d);
        total++;
        if (d !== 32'h0000_FFFF) begin
            bad++;
            $display("FAIL rej_period_mask: got %0h want ffff", d);
        end
        bus_write(A_CH_EN, 32'hFFFF_FFFF, 3'b010);
        bus_read(A_CH_EN, d);
        total++;
        if (d !== 32'h0000_000F) begin
            bad++;
            $display("FAIL rej_chen_mask: got %0h want f", d);
        end
    endtask

    task automatic test_wrap_disable();
        logic e;
        do_reset();
        setup(16'd0, 16'd9, 16'd3, 16'd0, 16'd0, 16'd0, 4'h1);
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            bus_idle();
            if (k <= 32) begin
                e = ((k - 1) % 10) < 3;
            end else if (k <= 36) begin
                e = 1'b0;
            end else begin
                e = ((k - 37) % 10) < 3;
            end
            total++;
            if (pwm_out[0] !== e) begin
                bad++;
                $display("FAIL wd_ch0 k=%0d: got %b want %b", k, pwm_out[0], e);
            end
            if (k == 20) begin
                total++;
                if (wrap_irq !== 1'b1) begin
                    bad++;
                    $display("FAIL wd_race_keep: got %b want 1", wrap_irq);
                end
            end
            if (k == 24) begin
                total++;
                if (wrap_irq !== 1'b0) begin
                    bad++;
                    $display("FAIL wd_clear: got %b want 0", wrap_irq);
                end
            end
            if (k == 33) begin
                total++;
                if (pwm_out !== 4'h0) begin
                    bad++;
                    $display("FAIL wd_disable_low: got %b want 0000", pwm_out);
                end
            end
            case (k)
                19: set_wr(A_CTRL, 32'h3, 3'b010);
                23: set_wr(A_CTRL, 32'h3, 3'b010);
                31: set_wr(A_CTRL, 32'h0, 3'b010);
                35: set_wr(A_CTRL, 32'h1, 3'b010);
                default: ;
            endcase
        end
    endtask

    initial begin
        bus_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_waveform();
        test_glitch(5, 10);
        test_glitch(9, 20);
        test_prescale();
        test_rejected();
        test_wrap_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_pwm.md
Name: mmio_pwm

Overview:
- Parametrised, memory-mapped PWM peripheral with NUM_CH channels.
- Replaces the on/off LED and RGB bits inside the memory block, giving the RV32I core per-channel duty control.
- Sits on the core's data-memory port behind the top-level address decoder and drives the board LED/RGB pins. Pin inversion stays at top level.
- Glitch-free updates: PERIOD and DUTY writes are double-buffered and take effect at period wrap.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16).
- WIDTH, 16, bit width of the period counter, PERIOD and DUTY registers (2..24).
- PRE_W, 16, bit width of the prescaler register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  chip select from the top-level address decoder.
- wren  in  1  write strobe; takes effect only when sel=1.
- funct3  in  3  access size. Only 3'b010 (word) writes are accepted; other sizes are ignored.
- addr  in  8  byte offset within the block; bits [1:0] are ignored.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- pwm_out  out  NUM_CH  active-high channel outputs, registered.
- wrap_irq  out  1  level copy of the sticky WRAP flag.

Behaviour:
- Register map (offset: field):
  - 0x00 CTRL: [0] EN (rw); [1] WRAP (sticky, write-1-to-clear).
  - 0x04 PRESCALE: [PRE_W-1:0].
  - 0x08 PERIOD: [WIDTH-1:0], pending copy.
  - 0x0C CH_EN: [NUM_CH-1:0].
  - 0x10+4*i DUTY[i]: [WIDTH-1:0], pending copy, for i < NUM_CH.
  - Unmapped offsets: reads return 0, writes are ignored.
  - Unused upper bits read 0.
- Reset:
  - All registers (pending and active), the prescaler counter and the period counter go to 0.
  - pwm_out=0, rdata=0, wrap_irq=0.
  - A reset in mid-period takes precedence over any same-cycle write.
- Reads:
  - rdata is updated on the clock edge after sel=1 with wren=0. It holds its value otherwise.
  - This gives one-cycle latency, matching read_data_clocked.
  - PERIOD and DUTY reads return the pending value.
- Prescaler:
  - pre_cnt counts 0..PRESCALE.
  - tick=1 in the cycle where pre_cnt==PRESCALE; pre_cnt then returns to 0.
  - PRESCALE=0 gives tick every cycle.
  - Runs only while EN=1. Held at 0 while EN=0.
- Period counter:
  - cnt advances on tick.
  - If cnt==period_act, cnt goes to 0 and a wrap event occurs.
  - Otherwise cnt increments, with WIDTH-bit arithmetic.
  - The period length is period_act+1 ticks.
- Shadow load:
  - On a wrap event, period_act and all duty_act[i] load from their pending copies.
  - While EN=0, active copies track pending copies every cycle.
  - A pending write in the same cycle as a wrap lands in pending. It becomes active at the following wrap.
- WRAP flag:
  - Set on every wrap event.
  - Cleared by a CTRL write with wdata[1]=1.
  - Set has priority over a simultaneous clear.
  - A CTRL write updates EN regardless of bit 1.
- Output:
  - Each cycle: pwm_out[i] <= EN & CH_EN[i] & (cnt < duty_act[i]).
  - One-cycle latency from cnt.
  - duty_act=0: constantly low.
  - duty_act > period_act: constantly high.
- EN 1->0:
  - cnt and pre_cnt clear on the next edge.
  - pwm_out goes low one cycle later.
  - Re-enabling starts from cnt=0.

Test Plan:
- Reset, then read every mapped offset: rdata=0 one cycle after each read; pwm_out=0.
- Single-channel waveform:
  - Setup: PRESCALE=0, PERIOD=9, DUTY0=3, CH_EN=1, EN=1.
  - Required: pwm_out[0] high for 3 cycles and low for 7, repeating every 10 cycles.
  - WRAP becomes 1 after the first period.
- Glitch-free update:
  - Mid-period at cnt=5, write DUTY0=7.
  - Required: the current period keeps 3 high cycles; the next period shows 7 high cycles.
  - Variant: the same write issued in the exact wrap cycle applies one period later.
- Prescaler and boundary duties:
  - Setup: PRESCALE=2, PERIOD=3, DUTY0=0, DUTY1=4, DUTY2=2.
  - Required: ch0 always low; ch1 always high; ch2 high 6 cycles, low 6 cycles.
- Rejected accesses:
  - Byte write (funct3=000) to DUTY0: ignored, readback unchanged.
  - Write to 0xFC: ignored.
  - Write with sel=0: ignored.
  - Read of 0xFC returns 0.
- WRAP W1C race and disable:
  - Write CTRL=0x3 in a wrap cycle: WRAP stays 1.
  - A later CTRL=0x3 write clears it.
  - Write EN=0: pwm_out all low within 2 cycles; cnt restarts at 0 on re-enable.
